// File: rtl/keypad_matrix_scanner.sv
// Key matrix scanner: walks the drive lines, debounces whole-matrix scans and hands each
// accepted press to the consumer through a valid/ack handshake with overrun reporting.
module keypad_matrix_scanner #(
    parameter int unsigned NUM_DRIVE      = 3,
    parameter int unsigned NUM_SENSE      = 4,
    parameter int unsigned SETTLE_CYCLES  = 3,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    localparam int unsigned CODE_W = (NUM_DRIVE * NUM_SENSE > 1) ?
                                     $clog2(NUM_DRIVE * NUM_SENSE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SENSE-1:0] sense_in,
    input  logic                 key_ack,
    output logic [NUM_DRIVE-1:0] drive_out,
    output logic [CODE_W-1:0]    key_code,
    output logic                 key_valid,
    output logic                 multi_key,
    output logic                 overrun
);

    localparam int unsigned DRV_W = (NUM_DRIVE > 1) ? $clog2(NUM_DRIVE) : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DRV_W-1:0] DRV_LAST    = DRV_W'(NUM_DRIVE - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       DB_MAX      = 4'(DEBOUNCE_SCANS);

    typedef enum logic [2:0] {StIdle, StDrive, StSample, StGap, StEval} state_e;
    typedef enum logic [1:0] {ClsNone, ClsSingle, ClsMulti} cls_e;

    state_e state_q, state_d;
    logic [DRV_W-1:0] drv_q, drv_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [NUM_SENSE-1:0] sense_meta_q, sense_s_q;
    logic [1:0] hits_q, hits_d;
    logic [CODE_W-1:0] scan_code_q, scan_code_d;
    cls_e cand_cls_q, cand_cls_d;
    logic [CODE_W-1:0] cand_code_q, cand_code_d;
    logic [3:0] db_cnt_q, db_cnt_d;
    logic pressed_q, pressed_d;
    logic key_valid_q, key_valid_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic overrun_q, overrun_d;
    logic multi_q, multi_d;

    logic [3:0] pop;
    logic [CODE_W-1:0] hit_code;
    cls_e res_cls;
    logic [CODE_W-1:0] res_code;
    logic press;

    // Scan sequencer; drive_out decodes the registered state so it is 0 while idle.
    always_comb begin
        state_d   = state_q;
        drv_d     = drv_q;
        settle_d  = settle_q;
        drive_out = '0;
        unique case (state_q)
            StIdle: begin
                state_d  = StDrive;
                drv_d    = '0;
                settle_d = '0;
            end
            StDrive: begin
                drive_out[drv_q] = 1'b1;
                if (settle_q == SETTLE_LAST) state_d = StSample;
                else settle_d = settle_q + 1'b1;
            end
            StSample: begin
                drive_out[drv_q] = 1'b1;
                state_d = StGap;
            end
            StGap: begin
                settle_d = '0;
                if (drv_q == DRV_LAST) begin
                    state_d = StEval;
                end else begin
                    drv_d   = drv_q + 1'b1;
                    state_d = StDrive;
                end
            end
            StEval: begin
                state_d  = StDrive;
                drv_d    = '0;
                settle_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Accumulate hits over the scan; the count saturates at 2 since only 0/1/many matter.
    always_comb begin
        pop      = '0;
        hit_code = '0;
        for (int j = 0; j < int'(NUM_SENSE); j++) begin
            if (sense_s_q[j]) begin
                pop      = pop + 4'd1;
                hit_code = CODE_W'(32'(drv_q) * NUM_SENSE + 32'(j));
            end
        end
        hits_d      = hits_q;
        scan_code_d = scan_code_q;
        if (state_q == StSample) begin
            if (pop > 4'd1 || (pop == 4'd1 && hits_q != 2'd0)) begin
                hits_d = 2'd2;
            end else if (pop == 4'd1) begin
                hits_d      = 2'd1;
                scan_code_d = hit_code;
            end
        end else if (state_q == StEval) begin
            hits_d      = '0;
            scan_code_d = '0;
        end
    end

    // Debounce at EVAL, then the consumer handshake.
    always_comb begin
        res_cls     = (hits_q == 2'd0) ? ClsNone : (hits_q == 2'd1) ? ClsSingle : ClsMulti;
        res_code    = (hits_q == 2'd1) ? scan_code_q : '0;
        cand_cls_d  = cand_cls_q;
        cand_code_d = cand_code_q;
        db_cnt_d    = db_cnt_q;
        pressed_d   = pressed_q;
        press       = 1'b0;
        multi_d     = 1'b0;
        if (state_q == StEval) begin
            multi_d = (res_cls == ClsMulti);
            if (res_cls == cand_cls_q && res_code == cand_code_q) begin
                if (db_cnt_q != DB_MAX) db_cnt_d = db_cnt_q + 4'd1;
            end else begin
                cand_cls_d  = res_cls;
                cand_code_d = res_code;
                db_cnt_d    = 4'd1;
            end
            if (db_cnt_d == DB_MAX) begin
                if (cand_cls_d == ClsSingle && !pressed_q) begin
                    press     = 1'b1;
                    pressed_d = 1'b1;
                end else if (cand_cls_d == ClsNone) begin
                    pressed_d = 1'b0;
                end
            end
        end

        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        if (press && (!key_valid_q || key_ack)) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_code_d;
            if (key_valid_q) overrun_d = 1'b0;
        end else if (press) begin
            overrun_d = 1'b1;
        end else if (key_valid_q && key_ack) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            drv_q        <= '0;
            settle_q     <= '0;
            sense_meta_q <= '0;
            sense_s_q    <= '0;
            hits_q       <= '0;
            scan_code_q  <= '0;
            cand_cls_q   <= ClsNone;
            cand_code_q  <= '0;
            db_cnt_q     <= '0;
            pressed_q    <= 1'b0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
            overrun_q    <= 1'b0;
            multi_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            drv_q        <= drv_d;
            settle_q     <= settle_d;
            sense_meta_q <= sense_in;
            sense_s_q    <= sense_meta_q;
            hits_q       <= hits_d;
            scan_code_q  <= scan_code_d;
            cand_cls_q   <= cand_cls_d;
            cand_code_q  <= cand_code_d;
            db_cnt_q     <= db_cnt_d;
            pressed_q    <= pressed_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            overrun_q    <= overrun_d;
            multi_q      <= multi_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign multi_key = multi_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: directed scenarios and a randomized run, checked
// cycle by cycle against a scan-level model of which keys each scan observes.
module tb_keypad_matrix_scanner;

    localparam int ND = 3;
    localparam int NS = 4;
    localparam int NK = ND * NS;
    localparam int P  = 16;
    localparam int DS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] sense_in;
    logic          key_ack;
    logic [ND-1:0] drive_out;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          multi_key;
    logic          overrun;
    logic [NK-1:0] keys;
    logic [9:0]    obs;

    keypad_matrix_scanner #(
        .NUM_DRIVE(ND),
        .NUM_SENSE(NS),
        .SETTLE_CYCLES(3),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sense_in(sense_in),
        .key_ack(key_ack),
        .drive_out(drive_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .multi_key(multi_key),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its drive row onto its sense column.
    always_comb begin
        sense_in = '0;
        for (int d = 0; d < ND; d++)
            for (int s = 0; s < NS; s++)
                if (drive_out[d] && keys[d*NS+s]) sense_in[s] = 1'b1;
    end

    assign obs = {drive_out, key_valid, key_code, multi_key, overrun};

    int            pos;
    logic [NK-1:0] snap;
    int            cand_cls, cand_code, cnt;
    bit            pressed, m_valid, m_ovr, m_multi;
    int            m_code;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Scan position p: drive d is high for p in [5d, 5d+3], GAP at 5d+4, EVAL at 15.
    function automatic logic [ND-1:0] exp_drive(int p);
        if (p < 0 || p == P - 1 || p % 5 == 4) return '0;
        return ND'(1 << (p / 5));
    endfunction

    function automatic logic [9:0] exp_vec();
        return {exp_drive(pos), m_valid, 4'(m_code), m_multi, m_ovr};
    endfunction

    task automatic model_reset();
        pos = -1; snap = '0;
        cand_cls = 0; cand_code = 0; cnt = 0; pressed = 0;
        m_valid = 0; m_ovr = 0; m_multi = 0; m_code = 0;
    endtask

    // One clock: the model sees row d as it stands two cycles before its sample slot.
    task automatic step(input bit ack);
        bit press, nm;
        int n, code, cls;
        press = 0; nm = 0;
        key_ack = ack;
        if (pos >= 0 && pos < P - 1 && pos % 5 == 1)
            snap[(pos/5)*NS +: NS] = keys[(pos/5)*NS +: NS];
        if (pos == P - 1) begin
            n = $countones(snap);
            code = 0;
            for (int k = 0; k < NK; k++) if (snap[k]) code = k;
            cls = (n == 0) ? 0 : (n == 1) ? 1 : 2;
            if (cls != 1) code = 0;
            if (cls == cand_cls && code == cand_code) begin
                if (cnt < DS) cnt++;
            end else begin
                cand_cls = cls; cand_code = code; cnt = 1;
            end
            if (cnt == DS && cls == 1 && !pressed) begin press = 1; pressed = 1; end
            if (cnt == DS && cls == 0) pressed = 0;
            nm = (cls == 2);
            snap = '0;
        end
        if (press) begin
            if (!m_valid || ack) begin
                if (m_valid) m_ovr = 0;
                m_valid = 1; m_code = cand_code;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && ack) begin
            m_valid = 0; m_ovr = 0;
        end
        m_multi = nm;
        @(posedge clk); #1;
        pos = (pos == P - 1) ? 0 : pos + 1;
    endtask

    // Leaves the bench at scan position 0 with the given keys applied.
    task automatic align(input logic [NK-1:0] k);
        for (int i = 0; i < P + 1 && pos != P - 1; i++) step(0);
        keys = k;
        step(0);
    endtask

    task automatic idle_scans(input int n);
        keys = '0;
        repeat (n * P) step(0);
    endtask

    task automatic test_reset();
        rst = 1'b0; keys = '0; key_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (obs !== 10'd0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", obs); end
        rst = 1'b1;
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle: got %b want %b", obs, exp_vec()); end
        step(0);
        n_cmp++;
        if (drive_out !== 3'b001) begin n_bad++; $display("FAIL first_drive: got %b want 001", drive_out); end
        for (int i = 0; i < 2 * P; i++) begin
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL walk pos %0d: got %b want %b", pos, obs, exp_vec()); end
            if (pos == 5 || pos == 10) begin
                n_cmp++;
                if (drive_out !== ((pos == 5) ? 3'b010 : 3'b100))
                    begin n_bad++; $display("FAIL walk_row pos %0d: got %b", pos, drive_out); end
            end
            step(0);
        end
        keys = '0; keys[5] = 1'b1;
        repeat (5 * P) begin
            step(0);
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL pre_reset: got %b want %b", obs, exp_vec()); end
        end
        n_cmp++;
        if (key_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_pending: got %b want 1", key_valid); end
        for (int i = 0; i < P + 1 && pos != 6; i++) step(0);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 10'd0) begin n_bad++; $display("FAIL midscan_reset: got %b want 0", obs); end
        keys = '0;
        model_reset();
        rst = 1'b1;
        step(0);
        n_cmp++;
        if ({drive_out, key_valid} !== 4'b0010)
            begin n_bad++; $display("FAIL post_reset: got %b want 0010", {drive_out, key_valid}); end
    endtask

    task automatic test_single_press();
        int first, rises;
        logic prev;
        logic [3:0] code_at;
        logic [NK-1:0] k;
        first = -1; rises = 0; prev = 1'b0; code_at = '0;
        k = '0; k[5] = 1'b1;
        align(k);
        for (int i = 1; i <= 6 * P; i++) begin
            step(i == 4 * P + 1);
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL single cyc %0d: got %b want %b", i, obs, exp_vec()); end
            if (key_valid && !prev) begin
                rises++;
                if (first < 0) begin first = i; code_at = key_code; end
            end
            prev = key_valid;
        end
        n_cmp++;
        if (first != 3 * P) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", first, 3 * P); end
        n_cmp++;
        if (code_at !== 4'd5) begin n_bad++; $display("FAIL single_code: got %0d want 5", code_at); end
        n_cmp++;
        if (rises != 1 || key_valid !== 1'b0)
            begin n_bad++; $display("FAIL single_once: got %0d rises valid %b want 1 rise valid 0", rises, key_valid); end
        idle_scans(4);
    endtask

    task automatic test_bounce();
        int first, rises;
        logic prev;
        logic [NK-1:0] k;
        first = -1; rises = 0; prev = 1'b0;
        k = '0; k[7] = 1'b1;
        align(k);
        for (int i = 0; i < 6 * P; i++) begin
            keys = (i >= 2 * P || (i / 7) % 2 == 0) ? k : '0;
            step(i == 85);
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL bounce cyc %0d: got %b want %b", i, obs, exp_vec()); end
            if (key_valid && !prev) begin
                rises++;
                if (first < 0) first = i + 1;
                n_cmp++;
                if (key_code !== 4'd7) begin n_bad++; $display("FAIL bounce_code: got %0d want 7", key_code); end
            end
            prev = key_valid;
        end
        n_cmp++;
        if (first != 5 * P || rises != 1)
            begin n_bad++; $display("FAIL bounce_emit: got at %0d x%0d want at %0d x1", first, rises, 5 * P); end
        idle_scans(4);
    endtask

    task automatic test_ghost();
        int first, pulses;
        logic prev;
        logic [NK-1:0] k;
        first = -1; pulses = 0; prev = 1'b0;
        k = '0; k[0] = 1'b1; k[11] = 1'b1;
        align(k);
        for (int i = 0; i < 9 * P; i++) begin
            if (i == 5 * P) keys[0] = 1'b0;
            step(i == 130);
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL ghost cyc %0d: got %b want %b", i, obs, exp_vec()); end
            if (multi_key) pulses++;
            if (key_valid && !prev && first < 0) begin
                first = i + 1;
                n_cmp++;
                if (key_code !== 4'd11) begin n_bad++; $display("FAIL ghost_code: got %0d want 11", key_code); end
            end
            prev = key_valid;
        end
        n_cmp++;
        if (pulses != 5) begin n_bad++; $display("FAIL ghost_pulses: got %0d want 5", pulses); end
        n_cmp++;
        if (first != 8 * P) begin n_bad++; $display("FAIL ghost_emit: got %0d want %0d", first, 8 * P); end
        idle_scans(4);
    endtask

    task automatic test_overrun();
        logic [NK-1:0] k;
        k = '0; k[2] = 1'b1;
        align(k);
        for (int i = 0; i < 9 * P + 2; i++) begin
            if (i == 3 * P) keys = '0;
            if (i == 6 * P) begin keys = '0; keys[9] = 1'b1; end
            step(0);
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL overrun cyc %0d: got %b want %b", i, obs, exp_vec()); end
        end
        n_cmp++;
        if ({key_valid, key_code, overrun} !== {1'b1, 4'd2, 1'b1})
            begin n_bad++; $display("FAIL overrun_state: got %b want 1_0010_1", {key_valid, key_code, overrun}); end
        step(1);
        n_cmp++;
        if ({key_valid, overrun} !== 2'b00)
            begin n_bad++; $display("FAIL overrun_ack: got %b want 00", {key_valid, overrun}); end
        idle_scans(4);
    endtask

    task automatic test_ack_collision();
        logic [NK-1:0] k;
        k = '0; k[3] = 1'b1;
        align(k);
        for (int i = 0; i < 9 * P; i++) begin
            if (i == 3 * P) keys = '0;
            if (i == 6 * P) begin keys = '0; keys[4] = 1'b1; end
            step(i == 9 * P - 1);
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL collide cyc %0d: got %b want %b", i, obs, exp_vec()); end
        end
        n_cmp++;
        if ({key_valid, key_code, overrun} !== {1'b1, 4'd4, 1'b0})
            begin n_bad++; $display("FAIL collide_state: got %b want 1_0100_0", {key_valid, key_code, overrun}); end
        step(1);
        n_cmp++;
        if (key_valid !== 1'b0) begin n_bad++; $display("FAIL collide_ack: got %b want 0", key_valid); end
        idle_scans(4);
    endtask

    task automatic test_random();
        int r, k1, k2;
        for (int i = 0; i < 2400; i++) begin
            if ($urandom_range(0, 23) == 0) begin
                r = $urandom_range(0, 9);
                keys = '0;
                if (r >= 4) begin
                    k1 = $urandom_range(0, NK - 1);
                    keys[k1] = 1'b1;
                    if (r == 9) begin
                        k2 = (k1 + $urandom_range(1, NK - 1)) % NK;
                        keys[k2] = 1'b1;
                    end
                end
            end
            step($urandom_range(0, 7) == 0);
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_ghost();
        test_overrun();
        test_ack_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
